// File: rtl/ad_block_sequencer_if.sv
// Bundle between the AD block sequencer, the top-level control FSM and the permutation controller.
// Latency: none (wires only).
// Backpressure: block_valid is held until block_ack; no other flow control.
//
// Ports (signals):
//   start/abort/ad_len   control FSM -> sequencer
//   block_ack            permutation controller -> sequencer
//   block_request        sequencer -> data source (fetch next RATE_BYTES of AD)
//   block_valid/datalen/last_block/pad_only  block descriptor to the permutation controller
//   AD_cntrl/dom_sep/done/block_cnt          phase status back to the control FSM
// Modports: master = sequencer side, slave = environment side.
interface ad_block_sequencer_if #(
  parameter int RATE_BYTES = 8,
  parameter int LEN_W      = 16
);
  localparam int DLEN_W = $clog2(RATE_BYTES) + 1;

  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  ad_len;
  logic              block_ack;
  logic              block_request;
  logic              block_valid;
  logic [DLEN_W-1:0] datalen;
  logic              last_block;
  logic              pad_only;
  logic              AD_cntrl;
  logic              dom_sep;
  logic              done;
  logic [LEN_W-1:0]  block_cnt;

  modport master (
    input  start, abort, ad_len, block_ack,
    output block_request, block_valid, datalen, last_block, pad_only,
           AD_cntrl, dom_sep, done, block_cnt
  );

  modport slave (
    output start, abort, ad_len, block_ack,
    input  block_request, block_valid, datalen, last_block, pad_only,
           AD_cntrl, dom_sep, done, block_cnt
  );
endinterface

// File: rtl/ad_block_sequencer.sv
// Splits the ASCON associated data into rate-sized blocks, adds the padding-only block, then pulses dom_sep and done.
// Latency: start -> first block_request 1 cycle; last ack -> dom_sep 1 cycle; dom_sep -> done 1 cycle.
// Backpressure: each descriptor is held on block_valid until block_ack; abort drops the phase at the next edge.
//
// Ports:
//   clk   clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   ad_block_sequencer_if.master (start/abort/ad_len/block_ack in; descriptor, request and status out)
module ad_block_sequencer #(
  parameter int RATE_BYTES = 8,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    nRST,
  ad_block_sequencer_if.master    bus
);
  localparam int DLEN_W = $clog2(RATE_BYTES) + 1;
  localparam logic [LEN_W-1:0]  RATE_L = LEN_W'(RATE_BYTES);
  localparam logic [DLEN_W-1:0] RATE_D = DLEN_W'(RATE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLOCK,
    S_PAD,
    S_SEP,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic              first, first_nxt;   // marks the first cycle of a BLOCK entry
  logic              rem_lt_rate;
  logic [DLEN_W-1:0] blk_len;

  // Current block size, derived only from registered rem.
  always_comb begin
    rem_lt_rate = (rem < RATE_L);
    blk_len     = rem_lt_rate ? rem[DLEN_W-1:0] : RATE_D;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      rem   <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    rem_nxt           = rem;
    cnt_nxt           = cnt;
    first_nxt         = 1'b0;
    bus.block_request = 1'b0;
    bus.block_valid   = 1'b0;
    bus.datalen       = '0;
    bus.last_block    = 1'b0;
    bus.pad_only      = 1'b0;
    bus.AD_cntrl      = 1'b0;
    bus.dom_sep       = 1'b0;
    bus.done          = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          rem_nxt = bus.ad_len;
          cnt_nxt = '0;
          if (bus.ad_len == '0) begin
            // Empty AD: ASCON skips absorption but still separates domains.
            state_nxt = S_SEP;
          end else begin
            state_nxt = S_BLOCK;
            first_nxt = 1'b1;
          end
        end
      end

      S_BLOCK: begin
        bus.block_valid   = 1'b1;
        bus.datalen       = blk_len;
        bus.last_block    = rem_lt_rate;
        bus.block_request = first;
        bus.AD_cntrl      = 1'b1;
        if (bus.block_ack) begin
          cnt_nxt = cnt + 1'b1;
          rem_nxt = rem - LEN_W'(blk_len);
          // Decided on rem before the subtract: a full final block needs a separate padding block.
          if (rem > RATE_L) begin
            state_nxt = S_BLOCK;
            first_nxt = 1'b1;
          end else if (rem == RATE_L) begin
            state_nxt = S_PAD;
          end else begin
            state_nxt = S_SEP;
          end
        end
      end

      S_PAD: begin
        bus.block_valid = 1'b1;
        bus.last_block  = 1'b1;
        bus.pad_only    = 1'b1;
        bus.AD_cntrl    = 1'b1;
        if (bus.block_ack) begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = S_SEP;
        end
      end

      S_SEP: begin
        bus.dom_sep = 1'b1;
        state_nxt   = S_DONE;
      end

      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides any ack taken above; the block count is left as it stands.
    if (bus.abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      rem_nxt   = '0;
      cnt_nxt   = cnt;
      first_nxt = 1'b0;
    end
  end

  assign bus.block_cnt = cnt;

endmodule

// File: tb/tb_ad_block_sequencer.sv
// Bench for ad_block_sequencer: one RATE=8 and one RATE=16 instance driven by directed vectors.
// Latency: expected events are pushed at stimulus time; a negedge monitor pops and compares.
// Backpressure: an auto-ack responder with per-instance delay, or manual ack under stimulus control.
module tb_ad_block_sequencer;
  localparam int K_REQ = 0, K_BLK = 1, K_SEP = 2, K_DONE = 3;

  typedef struct {
    int dut; int kind; int dlen; int last; int pad; int cnt; int gap;
  } ev_t;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  ad_block_sequencer_if #(.RATE_BYTES(8),  .LEN_W(16)) bus8 ();
  ad_block_sequencer_if #(.RATE_BYTES(16), .LEN_W(16)) bus16 ();

  ad_block_sequencer #(.RATE_BYTES(8),  .LEN_W(16)) u_seq8  (.clk(clk), .nRST(nRST), .bus(bus8));
  ad_block_sequencer #(.RATE_BYTES(16), .LEN_W(16)) u_seq16 (.clk(clk), .nRST(nRST), .bus(bus16));

  int  n_chk = 0;
  int  n_pass = 0;
  ev_t exp_q[$];
  int  mcyc = 0;

  bit  auto_ack [2];
  bit  m_ack    [2];
  bit  r_ack    [2];
  int  dly      [2];
  int  age      [2];
  bit  r_vld_last [2];

  assign bus8.block_ack  = auto_ack[0] ? r_ack[0] : m_ack[0];
  assign bus16.block_ack = auto_ack[1] ? r_ack[1] : m_ack[1];

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_ev(int d, int k, int dl, int l, int p, int c, int g);
    ev_t e;
    e.dut = d; e.kind = k; e.dlen = dl; e.last = l; e.pad = p; e.cnt = c; e.gap = g;
    exp_q.push_back(e);
  endtask

  // ---------------- responder ----------------
  task automatic resp_step(int d, bit vld, bit ack_cur);
    bit acc_last;
    acc_last = r_vld_last[d] && ack_cur;
    if (!vld || !r_vld_last[d] || acc_last) age[d] = 0;
    else age[d] = age[d] + 1;
    r_ack[d] = vld && (age[d] >= dly[d]);
    r_vld_last[d] = vld;
  endtask

  always @(posedge clk) begin
    #1;
    resp_step(0, bus8.block_valid, bus8.block_ack);
    resp_step(1, bus16.block_valid, bus16.block_ack);
  end

  // ---------------- monitor ----------------
  bit prev_vld [2];
  bit prev_acc [2];
  bit prev_abt [2];
  int prev_dl  [2];
  int last_cyc [2];

  task automatic emit(int d, int k, int dl, int l, int p, int c);
    ev_t e;
    int  gap;
    bit  ok;
    gap = mcyc - last_cyc[d];
    last_cyc[d] = mcyc;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got dut=%0d kind=%0d dlen=%0d last=%0d pad=%0d cnt=%0d, expected none",
               d, k, dl, l, p, c);
      return;
    end
    e = exp_q.pop_front();
    ok = (e.dut == d) && (e.kind == k) && (e.cnt == c) && ((e.gap < 0) || (e.gap == gap));
    if (k == K_BLK) ok = ok && (e.dlen == dl) && (e.last == l) && (e.pad == p);
    if (ok) n_pass++;
    else $display("FAIL event: got dut=%0d kind=%0d dlen=%0d last=%0d pad=%0d cnt=%0d gap=%0d, expected dut=%0d kind=%0d dlen=%0d last=%0d pad=%0d cnt=%0d gap=%0d",
                  d, k, dl, l, p, c, gap, e.dut, e.kind, e.dlen, e.last, e.pad, e.cnt, e.gap);
  endtask

  task automatic observe(int d, bit req, bit vld, bit ack, bit abt, int dl, bit l, bit p,
                         bit sep, bit dn, int c);
    if (!nRST) begin
      prev_vld[d] = 1'b0; prev_acc[d] = 1'b0; prev_abt[d] = 1'b0;
      return;
    end
    // A descriptor not yet taken must stay up and unchanged.
    if (prev_vld[d] && !prev_acc[d] && !prev_abt[d]) begin
      chk("hold_valid", vld, 1);
      chk("hold_datalen", dl, prev_dl[d]);
    end
    if (req) emit(d, K_REQ, 0, 0, 0, c);
    if (vld && ack && !abt) emit(d, K_BLK, dl, l, p, c);
    if (sep) emit(d, K_SEP, 0, 0, 0, c);
    if (dn)  emit(d, K_DONE, 0, 0, 0, c);
    prev_vld[d] = vld;
    prev_acc[d] = vld && ack;
    prev_abt[d] = abt;
    prev_dl[d]  = dl;
  endtask

  always @(negedge clk) begin
    mcyc++;
    observe(0, bus8.block_request, bus8.block_valid, bus8.block_ack, bus8.abort, int'(bus8.datalen),
            bus8.last_block, bus8.pad_only, bus8.dom_sep, bus8.done, int'(bus8.block_cnt));
    observe(1, bus16.block_request, bus16.block_valid, bus16.block_ack, bus16.abort, int'(bus16.datalen),
            bus16.last_block, bus16.pad_only, bus16.dom_sep, bus16.done, int'(bus16.block_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(int d, bit s, int len);
    if (d == 0) begin bus8.start = s;  bus8.ad_len = 16'(len);  end
    else        begin bus16.start = s; bus16.ad_len = 16'(len); end
  endtask

  // Returns #1 after the edge that accepted start.
  task automatic start_pulse(int d, int len);
    tick();
    set_start(d, 1'b1, len);
    tick();
    set_start(d, 1'b0, len);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 100)) begin tick(); n++; end
    repeat (3) tick();
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_idle(int d, int exp_cnt);
    if (d == 0) begin
      chk("idle8_vld_req_last_pad", {bus8.block_valid, bus8.block_request, bus8.last_block, bus8.pad_only}, 0);
      chk("idle8_ad_sep_done", {bus8.AD_cntrl, bus8.dom_sep, bus8.done}, 0);
      chk("idle8_datalen", bus8.datalen, 0);
      chk("idle8_block_cnt", bus8.block_cnt, exp_cnt);
    end else begin
      chk("idle16_vld_req_last_pad", {bus16.block_valid, bus16.block_request, bus16.last_block, bus16.pad_only}, 0);
      chk("idle16_ad_sep_done", {bus16.AD_cntrl, bus16.dom_sep, bus16.done}, 0);
      chk("idle16_datalen", bus16.datalen, 0);
      chk("idle16_block_cnt", bus16.block_cnt, exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bus8.start = 0;  bus8.abort = 0;  bus8.ad_len = 0;
    bus16.start = 0; bus16.abort = 0; bus16.ad_len = 0;
    auto_ack[0] = 1; auto_ack[1] = 1; dly[0] = 0; dly[1] = 0;
    m_ack[0] = 0; m_ack[1] = 0;

    // Reset state
    #3;
    chk_idle(0, 0);
    chk_idle(1, 0);
    tick();
    nRST = 1'b1;
    tick();

    // 1: empty AD -> straight to dom_sep then done
    expect_ev(0, K_SEP, 0, 0, 0, 0, -1);
    expect_ev(0, K_DONE, 0, 0, 0, 0, 1);
    start_pulse(0, 0);
    @(negedge clk);
    chk("t1_dom_sep_at_start_plus1", bus8.dom_sep, 1);
    chk("t1_valid_low", bus8.block_valid, 0);
    @(negedge clk);
    chk("t1_done_at_start_plus2", bus8.done, 1);
    drain();

    // 2: 5 bytes -> one short final block
    expect_ev(0, K_REQ, 0, 0, 0, 0, -1);
    expect_ev(0, K_BLK, 5, 1, 0, 0, 0);
    expect_ev(0, K_SEP, 0, 0, 0, 1, 1);
    expect_ev(0, K_DONE, 0, 0, 0, 1, 1);
    start_pulse(0, 5);
    @(negedge clk);
    chk("t2_request_at_start_plus1", bus8.block_request, 1);
    drain();
    chk("t2_block_cnt", bus8.block_cnt, 1);

    // 3: 16 bytes at rate 8 -> two full blocks plus padding block
    expect_ev(0, K_REQ, 0, 0, 0, 0, -1);
    expect_ev(0, K_BLK, 8, 0, 0, 0, 0);
    expect_ev(0, K_REQ, 0, 0, 0, 1, 1);
    expect_ev(0, K_BLK, 8, 0, 0, 1, 0);
    expect_ev(0, K_BLK, 0, 1, 1, 2, 1);
    expect_ev(0, K_SEP, 0, 0, 0, 3, 1);
    expect_ev(0, K_DONE, 0, 0, 0, 3, 1);
    start_pulse(0, 16);
    drain();
    chk("t3_block_cnt", bus8.block_cnt, 3);

    // 4: rate 16, 20 bytes, ack 3 cycles late per block
    dly[1] = 3;
    expect_ev(1, K_REQ, 0, 0, 0, 0, -1);
    expect_ev(1, K_BLK, 16, 0, 0, 0, 3);
    expect_ev(1, K_REQ, 0, 0, 0, 1, 1);
    expect_ev(1, K_BLK, 4, 1, 0, 1, 3);
    expect_ev(1, K_SEP, 0, 0, 0, 2, 1);
    expect_ev(1, K_DONE, 0, 0, 0, 2, 1);
    start_pulse(1, 20);
    drain();
    chk("t4_block_cnt", bus16.block_cnt, 2);

    // 5: abort together with the ack of the 2nd block
    expect_ev(0, K_REQ, 0, 0, 0, 0, -1);
    expect_ev(0, K_BLK, 8, 0, 0, 0, 0);
    expect_ev(0, K_REQ, 0, 0, 0, 1, 1);
    start_pulse(0, 24);
    tick();
    bus8.abort = 1'b1;
    tick();
    bus8.abort = 1'b0;
    chk_idle(0, 1);
    drain();

    // 6: stray acks in IDLE, start while busy, reset mid-block, then a clean run
    auto_ack[0] = 0;
    m_ack[0] = 1;
    tick(); tick();
    m_ack[0] = 0;
    chk("t6_stray_ack_cnt", bus8.block_cnt, 1);
    chk("t6_stray_ack_valid", bus8.block_valid, 0);
    expect_ev(0, K_REQ, 0, 0, 0, 0, -1);
    expect_ev(0, K_BLK, 8, 0, 0, 0, 2);
    expect_ev(0, K_REQ, 0, 0, 0, 1, 1);
    start_pulse(0, 24);
    tick();
    set_start(0, 1'b1, 3);
    tick();
    set_start(0, 1'b0, 3);
    m_ack[0] = 1;
    tick();
    m_ack[0] = 0;
    @(negedge clk);
    #1;
    nRST = 1'b0;
    #1;
    chk_idle(0, 0);
    tick();
    tick();
    nRST = 1'b1;
    chk("t6_queue_after_reset", exp_q.size(), 0);
    auto_ack[0] = 1;
    expect_ev(0, K_REQ, 0, 0, 0, 0, -1);
    expect_ev(0, K_BLK, 8, 0, 0, 0, 0);
    expect_ev(0, K_REQ, 0, 0, 0, 1, 1);
    expect_ev(0, K_BLK, 1, 1, 0, 1, 0);
    expect_ev(0, K_SEP, 0, 0, 0, 2, 1);
    expect_ev(0, K_DONE, 0, 0, 0, 2, 1);
    start_pulse(0, 9);
    drain();
    chk("t6_final_block_cnt", bus8.block_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
